// File: rtl/aes_inv_cipher_iter.sv
// Iterative AES-128 inverse cipher: one round per clock, round keys fetched by index.
// Optional abort input is enabled with the AES_INV_CIPHER_ABORT_EN macro.
module aes_inv_cipher_iter (
  input  logic         clk,
  input  logic         rst_n,
`ifdef AES_INV_CIPHER_ABORT_EN
  input  logic         abort_i,
`endif
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [127:0] ct_i,
  output logic [3:0]   rk_idx_o,
  input  logic [127:0] rk_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [127:0] pt_o,
  output logic         busy_o
);

  // state | meaning
  // IDLE  | waiting for ciphertext, key 10 presented for the initial AddRoundKey
  // ROUND | full inverse rounds, key index = counter (9..1)
  // FINAL | last round without InvMixColumns, key 0
  // DONE  | plaintext held until the consumer accepts it
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ROUND = 2'd1;
  localparam logic [1:0] FINAL = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [0:255][7:0] INV_SBOX = {
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // m is a 4-bit multiplier whose set bits select b, 2b, 4b, 8b
  function automatic logic [7:0] gmul(input logic [7:0] b, input logic [3:0] m);
    logic [7:0] b2, b4, b8, r;
    b2 = xtime(b);
    b4 = xtime(b2);
    b8 = xtime(b4);
    r  = 8'h00;
    if (m[0]) r = r ^ b;
    if (m[1]) r = r ^ b2;
    if (m[2]) r = r ^ b4;
    if (m[3]) r = r ^ b8;
    return r;
  endfunction

  function automatic logic [3:0] mix_coef(input logic [1:0] d);
    case (d)
      2'd0:    return 4'he;
      2'd1:    return 4'hb;
      2'd2:    return 4'hd;
      default: return 4'h9;
    endcase
  endfunction

  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[8*(4*c+r) +: 8] = s[8*(4*((c-r) & 3)+r) +: 8];
    return o;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 16; i++)
      o[8*i +: 8] = INV_SBOX[s[8*i +: 8]];
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        for (int k = 0; k < 4; k++)
          o[8*(4*c+r) +: 8] = o[8*(4*c+r) +: 8] ^
                              gmul(s[8*(4*c+k) +: 8], mix_coef(2'((k - r) & 3)));
    return o;
  endfunction

  logic [1:0]   fsm;
  logic [3:0]   cnt;
  logic [127:0] state;
  logic [127:0] ark;
  logic         abort_hit;

  // shared by ROUND and FINAL; FINAL skips the column mix
  assign ark = inv_sub_bytes(inv_shift_rows(state)) ^ rk_i;

`ifdef AES_INV_CIPHER_ABORT_EN
  assign abort_hit = abort_i && ((fsm == ROUND) || (fsm == FINAL));
`else
  assign abort_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm   <= IDLE;
      cnt   <= 4'd0;
      state <= '0;
      pt_o  <= '0;
    end else if (abort_hit) begin
      fsm   <= IDLE;
      cnt   <= 4'd0;
      state <= '0;
    end else begin
      case (fsm)
        IDLE: if (in_valid_i) begin
          state <= ct_i ^ rk_i;
          cnt   <= 4'd9;
          fsm   <= ROUND;
        end
        ROUND: begin
          state <= inv_mix_columns(ark);
          if (cnt == 4'd1) fsm <= FINAL;
          else             cnt <= cnt - 4'd1;
        end
        FINAL: begin
          pt_o <= ark;
          fsm  <= DONE;
        end
        DONE: if (out_ready_i) fsm <= IDLE;
        default: fsm <= IDLE;
      endcase
    end
  end

  always_comb begin
    rk_idx_o = 4'd10;
    case (fsm)
      ROUND:   rk_idx_o = cnt;
      FINAL:   rk_idx_o = 4'd0;
      DONE:    rk_idx_o = 4'd0;
      default: rk_idx_o = 4'd10;
    endcase
  end

  assign in_ready_o  = (fsm == IDLE);
  assign out_valid_o = (fsm == DONE);
  assign busy_o      = (fsm == ROUND) || (fsm == FINAL);

endmodule

// File: tb/tb_aes_inv_cipher_iter.sv
// Bench for aes_inv_cipher_iter: FIPS-197 C.1 decryption with handshake corner cases.
// Abort scenario is compiled in when AES_INV_CIPHER_ABORT_EN is defined.
module tb_aes_inv_cipher_iter;

  localparam logic [127:0] C1_CT = 128'h5ac5b47080b7cdd830047b6ad8e0c469;
  localparam logic [127:0] C1_PT = 128'hffeeddccbbaa99887766554433221100;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid_i;
  logic         in_ready_o;
  logic [127:0] ct_i;
  logic [3:0]   rk_idx_o;
  logic [127:0] rk_i;
  logic         out_valid_o;
  logic         out_ready_i;
  logic [127:0] pt_o;
  logic         busy_o;
`ifdef AES_INV_CIPHER_ABORT_EN
  logic         abort_i;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  aes_inv_cipher_iter dut (
    .clk         (clk),
    .rst_n       (rst_n),
`ifdef AES_INV_CIPHER_ABORT_EN
    .abort_i     (abort_i),
`endif
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .ct_i        (ct_i),
    .rk_idx_o    (rk_idx_o),
    .rk_i        (rk_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .pt_o        (pt_o),
    .busy_o      (busy_o)
  );

  always #5 clk = ~clk;

  // AES-128 key schedule of 000102..0f, written in FIPS byte order
  function automatic logic [127:0] key_fips(input logic [3:0] idx);
    case (idx)
      4'd0:    return 128'h000102030405060708090a0b0c0d0e0f;
      4'd1:    return 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
      4'd2:    return 128'hb692cf0b643dbdf1be9bc5006830b3fe;
      4'd3:    return 128'hb6ff744ed2c2c9bf6c590cbf0469bf41;
      4'd4:    return 128'h47f7f7bc95353e03f96c32bcfd058dfd;
      4'd5:    return 128'h3caaa3e8a99f9deb50f3af57adf622aa;
      4'd6:    return 128'h5e390f7df7a69296a7553dc10aa31f6b;
      4'd7:    return 128'h14f9701ae35fe28c440adf4d4ea9c026;
      4'd8:    return 128'h47438735a41c65b9e016baf4aebf7ad2;
      4'd9:    return 128'h549932d1f08557681093ed9cbe2c974e;
      4'd10:   return 128'h13111d7fe3944a17f307a78b4d2b30c5;
      default: return 128'h0;
    endcase
  endfunction

  // bus byte 0 sits in bits [7:0], the reverse of FIPS text order
  function automatic logic [127:0] byte_rev(input logic [127:0] x);
    logic [127:0] y;
    y = '0;
    for (int i = 0; i < 16; i++) y[8*i +: 8] = x[8*(15-i) +: 8];
    return y;
  endfunction

  assign rk_i = byte_rev(key_fips(rk_idx_o));

  typedef struct {
    logic [127:0] ct;
    logic [127:0] pt;
    int           hold;
    bit           scramble;
  } vec_t;

  vec_t vecs [3];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " in_ready"},  in_ready_o,  1);
    check({tag, " out_valid"}, out_valid_o, 0);
    check({tag, " busy"},      busy_o,      0);
    check({tag, " rk_idx"},    rk_idx_o,    10);
    check({tag, " pt"},        pt_o,        0);
  endtask

  task automatic run_block(input vec_t v);
    int guard;
    logic [127:0] held;
    guard = 0;
    while (!in_ready_o && guard < 40) begin
      step();
      guard++;
    end
    check("ready before transfer", in_ready_o, 1);
    ct_i        = v.ct;
    in_valid_i  = 1'b1;
    out_ready_i = (v.hold == 0);
    check("rk_idx at transfer", rk_idx_o, 10);
    step();
    in_valid_i = 1'b0;
    if (v.scramble) ct_i = ~v.ct;
    for (int j = 1; j <= 10; j++) begin
      check("rk_idx sequence", rk_idx_o, 128'(10 - j));
      check("busy in round", busy_o, 1);
      check("early out_valid", out_valid_o, 0);
      step();
    end
    check("latency out_valid", out_valid_o, 1);
    check("plaintext", pt_o, v.pt);
    check("busy in done", busy_o, 0);
    check("rk_idx in done", rk_idx_o, 0);
    held = pt_o;
    if (v.hold > 0) begin
      in_valid_i = 1'b1;
      for (int k = 0; k < v.hold; k++) begin
        step();
        check("hold out_valid", out_valid_o, 1);
        check("hold in_ready", in_ready_o, 0);
        check("hold pt stable", pt_o, held);
      end
      in_valid_i  = 1'b0;
      out_ready_i = 1'b1;
    end
    step();
    check("idle after accept", in_ready_o, 1);
    check("out_valid falls", out_valid_o, 0);
    check("no overlap accept", busy_o, 0);
    check("rk_idx in idle", rk_idx_o, 10);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc [4];
    int n_acc;
    int n_out;
    int guard;

    vecs[0] = '{ct: C1_CT, pt: C1_PT, hold: 0,  scramble: 1'b0};
    vecs[1] = '{ct: C1_CT, pt: C1_PT, hold: 20, scramble: 1'b1};
    vecs[2] = '{ct: C1_CT, pt: C1_PT, hold: 3,  scramble: 1'b1};

    rst_n       = 1'b0;
    in_valid_i  = 1'b0;
    out_ready_i = 1'b1;
    ct_i        = '0;
`ifdef AES_INV_CIPHER_ABORT_EN
    abort_i     = 1'b0;
`endif
    step();
    step();
    check_reset_outputs("reset");
    rst_n = 1'b1;
    step();

    for (int v = 0; v < 3; v++) run_block(vecs[v]);

    // back-to-back: accepts expected at cycles 0, 12, 24, 36
    ct_i        = C1_CT;
    in_valid_i  = 1'b1;
    out_ready_i = 1'b1;
    n_acc = 0;
    n_out = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (in_ready_o) begin
        if (n_acc < 4) acc[n_acc] = cyc;
        n_acc++;
      end
      if (out_valid_o) begin
        n_out++;
        check("b2b plaintext", pt_o, C1_PT);
      end
      step();
    end
    in_valid_i = 1'b0;
    check("b2b accept count", 128'(n_acc), 4);
    check("b2b output count", 128'(n_out), 3);
    check("b2b first accept", 128'(acc[0]), 0);
    check("b2b period 1", 128'(acc[1] - acc[0]), 12);
    check("b2b period 2", 128'(acc[2] - acc[1]), 12);
    guard = 0;
    while (!in_ready_o && guard < 30) begin
      step();
      guard++;
    end
    check("b2b drain", in_ready_o, 1);

    // reset in the fifth ROUND cycle
    ct_i       = C1_CT;
    in_valid_i = 1'b1;
    step();
    in_valid_i = 1'b0;
    for (int k = 0; k < 4; k++) step();
    check("round 5 rk_idx", rk_idx_o, 5);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid reset");
    step();
    check("in reset out_valid", out_valid_o, 0);
    rst_n = 1'b1;
    run_block(vecs[0]);

`ifdef AES_INV_CIPHER_ABORT_EN
    ct_i        = C1_CT;
    in_valid_i  = 1'b1;
    out_ready_i = 1'b1;
    step();
    in_valid_i = 1'b0;
    step();
    step();
    check("round 3 rk_idx", rk_idx_o, 7);
    abort_i = 1'b1;
    step();
    abort_i = 1'b0;
    check("abort idle", in_ready_o, 1);
    check("abort busy", busy_o, 0);
    check("abort pt kept", pt_o, C1_PT);
    for (int k = 0; k < 15; k++) begin
      check("abort no out_valid", out_valid_o, 0);
      step();
    end
    run_block(vecs[0]);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
